// File: rtl/mux_grant_arbiter.sv
// Two-requester round-robin arbiter driving the select line of a 2:1 data mux.
// A tenure counter forces a handover after MAX_HOLD cycles while the other side waits.
module mux_grant_arbiter #(
   parameter int MAX_HOLD = 8
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       ReqA,
   input  logic       ReqB,
   output logic       GntA,
   output logic       GntB,
   output logic       SEL,
   output logic       Busy,
   output logic [3:0] Tenure
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_A = 2'd1,
      GRANT_B = 2'd2
   } state_t;

   localparam logic [3:0] TENURE_MAX = 4'(MAX_HOLD - 1);

   state_t     state;
   state_t     next_state;
   logic [3:0] tenure_q;
   logic [3:0] tenure_d;
   logic       last_a_q;
   logic       last_a_d;
   logic       tenure_done;

   assign tenure_done = (tenure_q == TENURE_MAX);

   // State register. Reset is synchronous, so it lives inside the clocked branch.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state    <= IDLE;
         tenure_q <= 4'd0;
         last_a_q <= 1'b0;
      end else begin
         state    <= next_state;
         tenure_q <= tenure_d;
         last_a_q <= last_a_d;
      end
   end

   // Next-state logic: release, expiry and idle tie-break.
   // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (ReqA && ReqB)  next_state = last_a_q ? GRANT_B : GRANT_A;
            else if (ReqA)     next_state = GRANT_A;
            else if (ReqB)     next_state = GRANT_B;
         end
         GRANT_A: begin
            if (!ReqA || (tenure_done && ReqB)) next_state = ReqB ? GRANT_B : IDLE;
         end
         GRANT_B: begin
            if (!ReqB || (tenure_done && ReqA)) next_state = ReqA ? GRANT_A : IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Tenure restarts on any new grant and saturates while the owner keeps the mux.
   // LastA and SEL follow the same rule (track the most recent owner, hold in IDLE),
   // so one flop serves both.
   always_comb begin
      tenure_d = 4'd0;
      last_a_d = last_a_q;
      if (next_state != IDLE) begin
         last_a_d = (next_state == GRANT_A);
         if (next_state == state)
            tenure_d = tenure_done ? tenure_q : tenure_q + 4'd1;
      end
   end

   // Output decode from registered state only.
   always_comb begin
      GntA   = (state == GRANT_A);
      GntB   = (state == GRANT_B);
      Busy   = (state != IDLE);
      SEL    = last_a_q;
      Tenure = tenure_q;
   end

`ifndef SYNTHESIS
   a_onehot_grant : assert property (@(posedge Clock) disable iff (Reset) !(GntA && GntB));
   a_busy_match   : assert property (@(posedge Clock) disable iff (Reset) Busy == (GntA || GntB));
   a_tenure_range : assert property (@(posedge Clock) disable iff (Reset) Tenure <= TENURE_MAX);
   a_sel_follows  : assert property (@(posedge Clock) disable iff (Reset) Busy |-> (SEL == GntA));
`endif

endmodule
